// File: rtl/hub75_scan_driver.sv
// HUB75 32x32 1/16-scan driver with 8-plane binary-code modulation.
// Optional HUB75_GAMMA_EN squares each channel byte ((v*v)>>8) before plane-bit selection.
module hub75_scan_driver #(
  parameter int unsigned BASE_TICKS = 16,
  parameter int unsigned COLS       = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [8:0]  ram_address,
  input  logic [47:0] ram_data,
  output logic        r1,
  output logic        g1,
  output logic        b1,
  output logic        r2,
  output logic        g2,
  output logic        b2,
  output logic        sclk,
  output logic        lat,
  output logic        oe_n,
  output logic [3:0]  row_addr,
  output logic        frame_start
);

  localparam int unsigned SHIFT_CLKS = COLS * 4;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;

  state_t      state;
  logic [3:0]  row;
  logic [2:0]  plane;
  logic [6:0]  phase_cnt;
  logic [15:0] disp_cnt;
  logic [15:0] disp_last;
  logic [3:0]  next_row;
  logic [5:0]  plane_bits;

  function automatic logic [7:0] shade(input logic [7:0] v);
`ifdef HUB75_GAMMA_EN
    return 8'(({8'h00, v} * {8'h00, v}) >> 8);
`else
    return v;
`endif
  endfunction

  logic [7:0] ch_r1, ch_g1, ch_b1, ch_r2, ch_g2, ch_b2;

  always_comb begin
    ch_r1 = shade(ram_data[23:16]);
    ch_g1 = shade(ram_data[15:8]);
    ch_b1 = shade(ram_data[7:0]);
    ch_r2 = shade(ram_data[47:40]);
    ch_g2 = shade(ram_data[39:32]);
    ch_b2 = shade(ram_data[31:24]);
    plane_bits = {ch_r1[plane], ch_g1[plane], ch_b1[plane],
                  ch_r2[plane], ch_g2[plane], ch_b2[plane]};
  end

  assign disp_last = (16'(BASE_TICKS) << plane) - 16'd1;
  assign next_row  = (plane == 3'd7) ? row + 4'd1 : row;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      oe_n        <= 1'b1;
      sclk        <= 1'b0;
      lat         <= 1'b0;
      frame_start <= 1'b0;
      ram_address <= '0;
      row_addr    <= '0;
      {r1, g1, b1, r2, g2, b2} <= '0;
      row         <= '0;
      plane       <= '0;
      phase_cnt   <= '0;
      disp_cnt    <= '0;
    end else if (!enable) begin
      // Colour pins, row_addr and ram_address keep their last values while idle.
      state       <= IDLE;
      oe_n        <= 1'b1;
      sclk        <= 1'b0;
      lat         <= 1'b0;
      frame_start <= 1'b0;
      row         <= '0;
      plane       <= '0;
      phase_cnt   <= '0;
      disp_cnt    <= '0;
    end else begin
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          state       <= SHIFT;
          oe_n        <= 1'b1;
          sclk        <= 1'b0;
          lat         <= 1'b0;
          row         <= '0;
          plane       <= '0;
          phase_cnt   <= '0;
          ram_address <= '0;
          frame_start <= 1'b1;
        end
        SHIFT: begin
          phase_cnt <= phase_cnt + 7'd1;
          case (phase_cnt[1:0])
            2'd1: {r1, g1, b1, r2, g2, b2} <= plane_bits;
            2'd2: sclk <= 1'b1;
            2'd3: begin
              sclk <= 1'b0;
              if (phase_cnt == 7'(SHIFT_CLKS - 1)) begin
                state    <= LATCH;
                lat      <= 1'b1;
                row_addr <= row;
              end else begin
                ram_address <= {row, phase_cnt[6:2] + 5'd1};
              end
            end
            default: ;
          endcase
        end
        LATCH: begin
          state    <= DISPLAY;
          lat      <= 1'b0;
          oe_n     <= 1'b0;
          disp_cnt <= '0;
        end
        DISPLAY: begin
          if (disp_cnt == disp_last) begin
            state       <= SHIFT;
            oe_n        <= 1'b1;
            phase_cnt   <= '0;
            plane       <= plane + 3'd1;
            row         <= next_row;
            ram_address <= {next_row, 5'd0};
            frame_start <= (plane == 3'd7) && (row == 4'd15);
          end else begin
            disp_cnt <= disp_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Directed bench for hub75_scan_driver: reset, BCM passes over a full frame, frame period, enable drop.
module tb_hub75_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [8:0]  ram_address;
  logic [47:0] ram_data;
  logic        r1, g1, b1, r2, g2, b2;
  logic        sclk, lat, oe_n, frame_start;
  logic [3:0]  row_addr;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int mode    = 0;
  int t0      = 0;

  hub75_scan_driver #(.BASE_TICKS(16), .COLS(32)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .ram_address(ram_address), .ram_data(ram_data),
    .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
    .sclk(sclk), .lat(lat), .oe_n(oe_n),
    .row_addr(row_addr), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Pixel RAM: one clock of read latency.
  always @(posedge clk) begin
    case (mode)
      0:       ram_data <= 48'hFFFFFF_FFFFFF;
      1:       ram_data <= 48'h000000_800000;
      default: ram_data <= {40'h0, 3'b000, ram_address[4:0]};
    endcase
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Expected {r1,g1,b1,r2,g2,b2} for a pixel of column col in the given plane.
  function automatic logic [5:0] exp_bits(input int m, input int p, input int col);
    logic [7:0] v;
    if (m == 0) begin
`ifdef HUB75_GAMMA_EN
      return (p == 0) ? 6'b000000 : 6'b111111;
`else
      return 6'b111111;
`endif
    end else if (m == 1) begin
`ifdef HUB75_GAMMA_EN
      return (p == 6) ? 6'b100000 : 6'b000000;
`else
      return (p == 7) ? 6'b100000 : 6'b000000;
`endif
    end
`ifdef HUB75_GAMMA_EN
    v = 8'((col * col) >> 8);
`else
    v = 8'(col);
`endif
    return {2'b00, v[p], 3'b000};
  endfunction

  // Entered at the first SHIFT clk; leaves at the first DISPLAY clk.
  task automatic do_shift(input int row, input int plane);
    int err_addr = 0, err_sclk = 0, err_col = 0, err_oe = 0, err_fs = 0;
    logic [5:0] bits;
    for (int k = 0; k < 128; k++) begin
      if (ram_address !== 9'(row * 32 + k / 4)) err_addr++;
      if (sclk !== (k % 4 == 3)) err_sclk++;
      if (oe_n !== 1'b1 || lat !== 1'b0) err_oe++;
      if (frame_start !== (k == 0 && row == 0 && plane == 0)) err_fs++;
      if (sclk === 1'b1) begin
        bits = {r1, g1, b1, r2, g2, b2};
        if (bits !== exp_bits(mode, plane, k / 4)) err_col++;
      end
      tick();
    end
    check_eq($sformatf("addr_r%0d_p%0d", row, plane), err_addr, 0);
    check_eq($sformatf("sclk_r%0d_p%0d", row, plane), err_sclk, 0);
    check_eq($sformatf("colour_r%0d_p%0d", row, plane), err_col, 0);
    check_eq($sformatf("blank_r%0d_p%0d", row, plane), err_oe, 0);
    check_eq($sformatf("fstart_r%0d_p%0d", row, plane), err_fs, 0);
    check_eq($sformatf("latch_r%0d_p%0d", row, plane), {lat, oe_n, sclk, row_addr}, {3'b110, 4'(row)});
    tick();
  endtask

  task automatic do_display(input int row, input int plane);
    int n = 0;
    int limit = (16 << plane) + 4;
    while (oe_n === 1'b0 && n < limit) begin
      if (lat !== 1'b0 || sclk !== 1'b0) n += 1000000;
      n++;
      tick();
    end
    check_eq($sformatf("display_len_r%0d_p%0d", row, plane), n, 16 << plane);
  endtask

  initial begin
    // Reset state
    for (int i = 0; i < 3; i++) tick();
    check_eq("reset_oe_n", oe_n, 1);
    check_eq("reset_ctrl", {sclk, lat, frame_start}, 0);
    check_eq("reset_addr", ram_address, 0);
    check_eq("reset_row_addr", row_addr, 0);
    check_eq("reset_colour", {r1, g1, b1, r2, g2, b2}, 0);

    rst = 1'b1;
    enable = 1'b1;
    tick();
    t0 = cyc;
    check_eq("start_frame_start", frame_start, 1);
    check_eq("start_addr", ram_address, 0);

    // Frame 1: row 1 carries the single-bit pattern, row 5 a per-column pattern.
    for (int r = 0; r < 16; r++) begin
      mode = (r == 1) ? 1 : (r == 5) ? 2 : 0;
      for (int p = 0; p < 8; p++) begin
        do_shift(r, p);
        do_display(r, p);
      end
    end
    check_eq("frame_period", cyc - t0, 81792);
    check_eq("frame2_start", frame_start, 1);
    mode = 0;

    // Frame 2: drop enable during row 3 DISPLAY.
    for (int r = 0; r < 3; r++)
      for (int p = 0; p < 8; p++) begin
        do_shift(r, p);
        do_display(r, p);
      end
    do_shift(3, 0);
    for (int i = 0; i < 4; i++) tick();
    check_eq("mid_display_oe_n", oe_n, 0);
    enable = 1'b0;
    tick();
    check_eq("drop_oe_n", oe_n, 1);
    check_eq("drop_ctrl", {sclk, lat, frame_start}, 0);
    check_eq("drop_row_addr", row_addr, 3);
    check_eq("drop_colour_hold", {r1, g1, b1, r2, g2, b2}, exp_bits(0, 0, 31));
    tick();
    tick();
    check_eq("idle_oe_n", oe_n, 1);
    check_eq("idle_addr_hold", ram_address, 127);
    check_eq("idle_frame_start", frame_start, 0);
    enable = 1'b1;
    tick();
    check_eq("restart_frame_start", frame_start, 1);
    check_eq("restart_addr", ram_address, 0);
    check_eq("restart_oe_n", oe_n, 1);
    tick();
    check_eq("restart_fs_single", frame_start, 0);
    check_eq("restart_addr_hold", ram_address, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
